// File: rtl/store_monitor.sv
// Watches the core's data-memory store port, latches a sticky pass/fail verdict
// and queues every store in a first-word-fall-through FIFO for a trace consumer.
module store_monitor #(
  parameter logic [31:0] PASS_ADDR  = 32'd84,
  parameter logic [31:0] PASS_DATA  = 32'd7,
  parameter logic [31:0] ALLOW_ADDR = 32'd80,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memwrite,
  input  logic [31:0]      dataaddr,
  input  logic [31:0]      writedata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_addr,
  output logic [31:0]      out_data,
  output logic             pass,
  output logic             fail,
  output logic             done,
  output logic             overflow,
  output logic [CNT_W-1:0] store_count,
  output logic [CNT_W-1:0] drop_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = (PTR_W+1)'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PASS = 2'd1,
    ST_FAIL = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [PTR_W:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]     rd_ptr_q, rd_ptr_d;
  logic [31:0]        addr_mem_q [DEPTH];
  logic [31:0]        data_mem_q [DEPTH];
  logic               pass_q, pass_d;
  logic               fail_q, fail_d;
  logic               done_q, done_d;
  logic               ovf_q, ovf_d;
  logic [CNT_W-1:0]   store_cnt_q, store_cnt_d;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
  logic               empty_s, full_s, pop_s, push_s, drop_s;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign empty_s = (wr_ptr_q == rd_ptr_q);
  assign full_s  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign pop_s   = !empty_s && out_ready;
  assign push_s  = memwrite && (!full_s || pop_s);
  assign drop_s  = memwrite && full_s && !pop_s;

  assign out_valid   = !empty_s;
  assign out_addr    = addr_mem_q[rd_ptr_q[PTR_W-1:0]];
  assign out_data    = data_mem_q[rd_ptr_q[PTR_W-1:0]];
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign done        = done_q;
  assign overflow    = ovf_q;
  assign store_count = store_cnt_q;
  assign drop_count  = drop_cnt_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (memwrite) begin
          if ((dataaddr == PASS_ADDR) && (writedata == PASS_DATA)) begin
            state_d = ST_PASS;
          end else if (dataaddr != ALLOW_ADDR) begin
            state_d = ST_FAIL;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_PASS: state_d = ST_PASS;
      ST_FAIL: state_d = ST_FAIL;
      default: state_d = ST_FAIL;
    endcase
    pass_d = (state_d == ST_PASS);
    fail_d = (state_d == ST_FAIL);
    done_d = pass_d || fail_d;
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    store_cnt_d = store_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    ovf_d       = ovf_q || drop_s;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (memwrite && (store_cnt_q != CNT_MAX)) begin
      store_cnt_d = store_cnt_q + CNT_ONE;
    end else begin
      store_cnt_d = store_cnt_q;
    end
    if (drop_s && (drop_cnt_q != CNT_MAX)) begin
      drop_cnt_d = drop_cnt_q + CNT_ONE;
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
  end

  // Control and status registers; reset overrides any same-edge store or pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      store_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
      store_cnt_q <= store_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  // Storage needs no reset: entries are only visible between the pointers.
  always_ff @(posedge clk) begin
    if (push_s && !reset) begin
      addr_mem_q[wr_ptr_q[PTR_W-1:0]] <= dataaddr;
      data_mem_q[wr_ptr_q[PTR_W-1:0]] <= writedata;
    end
  end

endmodule
